pipe_ctrl: RTL

Parametrised pipeline hazard and redirect controller for the ECNURVCORE pipeline, superseding the fixed hold-code controller. It produces one hold bit and one flush bit per pipeline register, so the stage count and the memory-stage position are configurable. It adds three things the old controller lacks:
- fetch-address checking against the predicted PC;
- an exactly-one-cycle load-use bubble;
- a pending-redirect buffer that parks a redirect while the fetch bus is stalled.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipe_ctrl_redirect_buf.sv | 32 +++
 rtl/pipe_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/redirect controller.
// Latency: none (package only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PCTL_RUN  = 2'd0,   // normal flow
        PCTL_LU   = 2'd1,   // load-use bubble was issued last cycle
        PCTL_PEND = 2'd2    // redirect parked behind a stalled fetch bus
    } pctl_state_t;

    localparam int STG_PC   = 0;
    localparam int STG_IFID = 1;
    localparam int STG_IDEX = 2;

endpackage

// File: rtl/pipe_ctrl_redirect_buf.sv
// Pending-redirect register: parks one fetch address plus a valid flag.
// Latency: load/clear take effect at the next rising edge.
// Backpressure: none; load wins over clear and overwrites any parked entry.
//
// Ports: clk, rst_n (async active-low); load/load_pc write an entry;
// clear drops it; pend_vld/pend_pc expose the parked entry.
module redirect_buf #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              pend_vld,
    output logic [ADDR_W-1:0] pend_pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            pend_pc  <= '0;
        end else if (load) begin
            pend_vld <= 1'b1;
            pend_pc  <= load_pc;
        end else if (clear) begin
            pend_vld <= 1'b0;
            pend_pc  <= '0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: per-register hold/flush, PC redirect.
// Latency: zero-cycle inputs-to-outputs; PC takes redirect at the next edge.
// Backpressure: stall_mem_i freezes 0..MEM_STAGE; stall_if_i parks redirects.
//
// Ports: stall/hazard/branch/irq inputs; hold_o/flush_o one bit per pipeline
// register (0 = PC); redirect_o/redirect_pc_o new fetch address; irq_ack_o.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int NSTAGE      = 4,
    parameter int MEM_STAGE   = NSTAGE - 1,
    parameter int INSTR_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_if_i,
    input  logic              stall_mem_i,
    input  logic              load_use_i,
    input  logic              br_valid_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic [ADDR_W-1:0] br_pc_i,
    input  logic [ADDR_W-1:0] pc_pred_i,
    input  logic              irq_req_i,
    input  logic [ADDR_W-1:0] irq_vec_i,
    output logic              irq_ack_o,
    output logic [NSTAGE-1:0] hold_o,
    output logic [NSTAGE-1:0] flush_o,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirect_pc_o
);

    pctl_state_t       state, state_nxt;
    logic [ADDR_W-1:0] nxt_pc;
    logic              mispred;
    logic              sel_vld;
    logic [ADDR_W-1:0] sel_pc;
    logic              buf_load, buf_clear;
    logic              pend_vld;
    logic [ADDR_W-1:0] pend_pc;
    // Per-event hold/flush requests, expanded to bit vectors below.
    logic              h_mem, h_pc, h_ifid;
    logic              f_ifid, f_idex, f_irq;

    assign nxt_pc  = br_taken_i ? br_target_i : br_pc_i + ADDR_W'(INSTR_BYTES);
    assign mispred = br_valid_i && (nxt_pc != pc_pred_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PCTL_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        sel_vld    = 1'b0;
        sel_pc     = '0;
        redirect_o = 1'b0;
        irq_ack_o  = 1'b0;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        h_mem      = 1'b0;
        h_pc       = 1'b0;
        h_ifid     = 1'b0;
        f_ifid     = 1'b0;
        f_idex     = 1'b0;
        f_irq      = 1'b0;

        if (stall_mem_i) begin
            h_mem = 1'b1;
        end else begin
            // A load_use_i held across cycles is the same dependency; the
            // bubble already issued covers it, so stay in LU until it drops.
            if (state == PCTL_LU)
                state_nxt = load_use_i ? PCTL_LU : PCTL_RUN;

            if (irq_req_i || mispred) begin
                sel_vld = 1'b1;
                if (irq_req_i) begin
                    sel_pc    = irq_vec_i;
                    irq_ack_o = 1'b1;
                    f_irq     = 1'b1;
                end else begin
                    sel_pc = nxt_pc;
                    f_ifid = 1'b1;
                end
                if (stall_if_i) begin
                    buf_load  = 1'b1;
                    h_pc      = 1'b1;
                    state_nxt = PCTL_PEND;
                end else begin
                    redirect_o = 1'b1;
                    buf_clear  = 1'b1;
                    state_nxt  = PCTL_RUN;
                end
            end else if (load_use_i && state == PCTL_RUN) begin
                h_pc      = 1'b1;
                h_ifid    = 1'b1;
                f_idex    = 1'b1;
                state_nxt = PCTL_LU;
            end else if (state == PCTL_PEND && !stall_if_i) begin
                redirect_o = 1'b1;
                f_ifid     = 1'b1;
                buf_clear  = 1'b1;
                state_nxt  = PCTL_RUN;
            end else if (stall_if_i) begin
                h_pc   = 1'b1;
                f_ifid = 1'b1;
            end
        end
    end

    // While parked, show the buffered address unless a fresh redirect is
    // being issued right now; otherwise show the selected target (0 if none).
    assign redirect_pc_o = (pend_vld && !(redirect_o && sel_vld)) ? pend_pc : sel_pc;

    redirect_buf #(.ADDR_W(ADDR_W)) u_redirect_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (buf_load),
        .clear    (buf_clear),
        .load_pc  (sel_pc),
        .pend_vld (pend_vld),
        .pend_pc  (pend_pc)
    );

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam bit IS_PC   = (k == STG_PC);
        localparam bit IS_IFID = (k == STG_IFID);
        localparam bit IS_IDEX = (k == STG_IDEX);
        localparam bit IN_MEM  = (k <= MEM_STAGE);
        localparam bit IN_IRQ  = (k >= 1) && (k <= MEM_STAGE - 1);

        logic hold_raw;
        assign hold_raw   = (IN_MEM && h_mem) || (IS_PC && h_pc) || (IS_IFID && h_ifid);
        assign flush_o[k] = (IS_IFID && f_ifid) || (IS_IDEX && f_idex) || (IN_IRQ && f_irq);
        // A register being flushed must not also be held.
        assign hold_o[k]  = hold_raw && !flush_o[k];
    end

endmodule
